// File: rtl/prbs_pkg.sv
// Shared PRBS-15 definitions: polynomial taps, checker state type and byte-step helpers.
// Used by the checker and by the generator stage through prbs15_byte_predict.
package prbs_pkg;

   localparam int unsigned PRBS_W     = 15;
   localparam int unsigned PRBS_TAP_A = 14;
   localparam int unsigned PRBS_TAP_B = 13;

   typedef enum logic {SEARCH, LOCKED} chk_state_t;

   typedef struct packed {
      logic [PRBS_W-1:0] state;
      logic [7:0]        data;
   } prbs_step_t;

   // Eight serial steps; the first generated bit lands in data[7].
   function automatic prbs_step_t prbs15_step8(input logic [PRBS_W-1:0] state);
      prbs_step_t        res;
      logic [PRBS_W-1:0] s;
      logic              nb;
      s        = state;
      res.data = '0;
      for (int i = 0; i < 8; i++) begin
         nb           = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
         s            = {s[PRBS_W-2:0], nb};
         res.data[7-i] = nb;
      end
      res.state = s;
      return res;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] b);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, b[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/prbs15_checker_if.sv
// Byte stream and status bundle between a PRBS-15 source and the checker.
// PRBS_CHK_BYTECNT_EN adds the locked-byte counter signal.
interface prbs15_checker_if #(
   parameter int unsigned ERR_CNT_W = 32
) ();

   logic [7:0]           data_in;
   logic                 data_valid;
   logic                 clear;
   logic                 locked;
   logic                 err_byte;
   logic [3:0]           err_bits;
   logic [ERR_CNT_W-1:0] err_count;
   logic                 lock_loss;
`ifdef PRBS_CHK_BYTECNT_EN
   logic [31:0]          byte_count;
`endif

   modport master (
`ifdef PRBS_CHK_BYTECNT_EN
      input  byte_count,
`endif
      output data_in,
      output data_valid,
      output clear,
      input  locked,
      input  err_byte,
      input  err_bits,
      input  err_count,
      input  lock_loss
   );

   modport slave (
`ifdef PRBS_CHK_BYTECNT_EN
      output byte_count,
`endif
      input  data_in,
      input  data_valid,
      input  clear,
      output locked,
      output err_byte,
      output err_bits,
      output err_count,
      output lock_loss
   );

endinterface

// File: rtl/prbs15_byte_predict.sv
// Combinational PRBS-15 byte predictor: next 8 sequence bits and the advanced state.
module prbs15_byte_predict
   import prbs_pkg::*;
(
   input  logic [PRBS_W-1:0] i_state,
   output logic [7:0]        o_pred_byte,
   output logic [PRBS_W-1:0] o_next_state
);

   prbs_step_t w_step;

   assign w_step       = prbs15_step8(i_state);
   assign o_pred_byte  = w_step.data;
   assign o_next_state = w_step.state;

endmodule

// File: rtl/prbs15_checker.sv
// PRBS-15 byte-stream checker: self-synchronising lock FSM plus bit-error accounting.
// Optional PRBS_CHK_BYTECNT_EN adds a saturating count of bytes checked while locked.
module prbs15_checker
   import prbs_pkg::*;
#(
   parameter int unsigned LOCK_BYTES   = 4,
   parameter int unsigned UNLOCK_BYTES = 4,
   parameter int unsigned UNLOCK_BITS  = 2,
   parameter int unsigned ERR_CNT_W    = 32
) (
   input logic               clk,
   input logic               rst_n,
   prbs15_checker_if.slave   bus
);

   localparam logic [3:0] LockLast   = 4'(LOCK_BYTES - 1);
   localparam logic [3:0] UnlockLast = 4'(UNLOCK_BYTES - 1);
   localparam logic [3:0] BadBits    = 4'(UNLOCK_BITS);

   chk_state_t           r_state,     w_state_nxt;
   logic [PRBS_W-1:0]    r_prbs,      w_prbs_nxt;
   logic [1:0]           r_fill,      w_fill_nxt;
   logic [3:0]           r_good,      w_good_nxt;
   logic [3:0]           r_bad,       w_bad_nxt;
   logic                 r_err_byte,  w_err_byte_nxt;
   logic [3:0]           r_err_bits,  w_err_bits_nxt;
   logic [ERR_CNT_W-1:0] r_err_count, w_err_count_nxt;
   logic                 r_lock_loss, w_lock_loss_nxt;

   logic [7:0]           w_pred_byte;
   logic [PRBS_W-1:0]    w_pred_state;
   logic [3:0]           w_diff_bits;
   logic [ERR_CNT_W:0]   w_err_sum;

`ifdef PRBS_CHK_BYTECNT_EN
   logic [31:0]          r_byte_count, w_byte_count_nxt;
   logic [32:0]          w_byte_sum;
   assign w_byte_sum = {1'b0, r_byte_count} + 33'd1;
`endif

   prbs15_byte_predict u_predict (
      .i_state      (r_prbs),
      .o_pred_byte  (w_pred_byte),
      .o_next_state (w_pred_state)
   );

   assign w_diff_bits = popcount8(bus.data_in ^ w_pred_byte);
   assign w_err_sum   = {1'b0, r_err_count} + {{(ERR_CNT_W-3){1'b0}}, w_diff_bits};

   always_comb begin
      w_state_nxt     = r_state;
      w_prbs_nxt      = r_prbs;
      w_fill_nxt      = r_fill;
      w_good_nxt      = r_good;
      w_bad_nxt       = r_bad;
      w_err_byte_nxt  = 1'b0;
      w_err_bits_nxt  = r_err_bits;
      w_err_count_nxt = r_err_count;
      w_lock_loss_nxt = 1'b0;
`ifdef PRBS_CHK_BYTECNT_EN
      w_byte_count_nxt = r_byte_count;
`endif
      if (bus.data_valid) begin
         unique case (r_state)
            SEARCH: begin
               // Track the received stream; an all-zero register can never lock.
               w_prbs_nxt     = {r_prbs[PRBS_W-9:0], bus.data_in};
               w_err_bits_nxt = '0;
               if (r_fill != 2'd2) begin
                  w_fill_nxt = r_fill + 2'd1;
               end else if ((bus.data_in == w_pred_byte) && (r_prbs != '0)) begin
                  if (r_good == LockLast) begin
                     w_state_nxt = LOCKED;
                     w_good_nxt  = '0;
                     w_bad_nxt   = '0;
                  end else begin
                     w_good_nxt = r_good + 4'd1;
                  end
               end else begin
                  w_good_nxt = '0;
               end
            end
            LOCKED: begin
               // Free-run on the prediction so a corrupted byte does not poison later ones.
               w_prbs_nxt      = w_pred_state;
               w_err_bits_nxt  = w_diff_bits;
               w_err_byte_nxt  = (w_diff_bits != 4'd0);
               w_err_count_nxt = w_err_sum[ERR_CNT_W] ? '1 : w_err_sum[ERR_CNT_W-1:0];
`ifdef PRBS_CHK_BYTECNT_EN
               w_byte_count_nxt = w_byte_sum[32] ? '1 : w_byte_sum[31:0];
`endif
               if (w_diff_bits >= BadBits) begin
                  if (r_bad == UnlockLast) begin
                     w_state_nxt     = SEARCH;
                     w_lock_loss_nxt = 1'b1;
                     w_fill_nxt      = '0;
                     w_good_nxt      = '0;
                     w_bad_nxt       = '0;
                  end else begin
                     w_bad_nxt = r_bad + 4'd1;
                  end
               end else begin
                  w_bad_nxt = '0;
               end
            end
            default: w_state_nxt = SEARCH;
         endcase
      end
      if (bus.clear) begin
         w_err_count_nxt = '0;
`ifdef PRBS_CHK_BYTECNT_EN
         w_byte_count_nxt = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SEARCH;
         r_prbs      <= '0;
         r_fill      <= '0;
         r_good      <= '0;
         r_bad       <= '0;
         r_err_byte  <= 1'b0;
         r_err_bits  <= '0;
         r_err_count <= '0;
         r_lock_loss <= 1'b0;
`ifdef PRBS_CHK_BYTECNT_EN
         r_byte_count <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_prbs      <= w_prbs_nxt;
         r_fill      <= w_fill_nxt;
         r_good      <= w_good_nxt;
         r_bad       <= w_bad_nxt;
         r_err_byte  <= w_err_byte_nxt;
         r_err_bits  <= w_err_bits_nxt;
         r_err_count <= w_err_count_nxt;
         r_lock_loss <= w_lock_loss_nxt;
`ifdef PRBS_CHK_BYTECNT_EN
         r_byte_count <= w_byte_count_nxt;
`endif
      end
   end

   assign bus.locked    = (r_state == LOCKED);
   assign bus.err_byte  = r_err_byte;
   assign bus.err_bits  = r_err_bits;
   assign bus.err_count = r_err_count;
   assign bus.lock_loss = r_lock_loss;
`ifdef PRBS_CHK_BYTECNT_EN
   assign bus.byte_count = r_byte_count;
`endif

endmodule

// File: tb/tb_prbs15_checker.sv
// Randomised bench for prbs15_checker: two instances (32-bit and 4-bit error counters)
// share one stimulus stream and are compared each cycle against a bit-list reference model.
module tb_prbs15_checker;

   localparam int LOCK_BYTES   = 4;
   localparam int UNLOCK_BYTES = 4;
   localparam int UNLOCK_BITS  = 2;

   typedef bit hist_t [15];

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_valid;
   logic       clear;

   prbs15_checker_if #(.ERR_CNT_W(32)) bus32 ();
   prbs15_checker_if #(.ERR_CNT_W(4))  bus4 ();

   assign bus32.data_in    = data_in;
   assign bus32.data_valid = data_valid;
   assign bus32.clear      = clear;
   assign bus4.data_in     = data_in;
   assign bus4.data_valid  = data_valid;
   assign bus4.clear       = clear;

   prbs15_checker #(
      .LOCK_BYTES(LOCK_BYTES), .UNLOCK_BYTES(UNLOCK_BYTES), .UNLOCK_BITS(UNLOCK_BITS),
      .ERR_CNT_W(32)
   ) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

   prbs15_checker #(
      .LOCK_BYTES(LOCK_BYTES), .UNLOCK_BYTES(UNLOCK_BYTES), .UNLOCK_BITS(UNLOCK_BITS),
      .ERR_CNT_W(4)
   ) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 0;

   // Reference model: bit histories (index 0 oldest) extended by b[n] = b[n-15] ^ b[n-14].
   hist_t  g_hist;
   hist_t  m_hist;
   int     m_fill, m_good, m_bad;
   bit     e_locked, e_err_byte, e_lock_loss;
   int     e_err_bits;
   longint e_total, e_bytes;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] extend8(input hist_t h, output hist_t nh);
      bit         a [23];
      logic [7:0] b;
      for (int i = 0; i < 15; i++) a[i] = h[i];
      for (int k = 0; k < 8; k++) begin
         a[15+k] = a[k] ^ a[k+1];
         b[7-k]  = a[15+k];
      end
      for (int i = 0; i < 15; i++) nh[i] = a[8+i];
      return b;
   endfunction

   function automatic logic [7:0] gen_next();
      hist_t nh;
      logic [7:0] b;
      b = extend8(g_hist, nh);
      g_hist = nh;
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 15; i++) m_hist[i] = 0;
      m_fill = 0; m_good = 0; m_bad = 0;
      e_locked = 0; e_err_byte = 0; e_lock_loss = 0; e_err_bits = 0;
      e_total = 0; e_bytes = 0;
   endtask

   task automatic model_step(input logic [7:0] d, input bit v, input bit clr);
      hist_t nh;
      logic [7:0] pred;
      int diff;
      bit nz;
      e_err_byte  = 0;
      e_lock_loss = 0;
      if (v) begin
         pred = extend8(m_hist, nh);
         if (!e_locked) begin
            nz = 0;
            for (int i = 0; i < 15; i++) nz |= m_hist[i];
            e_err_bits = 0;
            if (m_fill < 2) m_fill++;
            else if (d == pred && nz) begin
               m_good++;
               if (m_good == LOCK_BYTES) begin
                  e_locked = 1; m_good = 0; m_bad = 0;
               end
            end else m_good = 0;
            for (int i = 0; i < 7; i++) m_hist[i] = m_hist[i+8];
            for (int k = 0; k < 8; k++) m_hist[7+k] = d[7-k];
         end else begin
            diff       = $countones(d ^ pred);
            e_err_bits = diff;
            e_err_byte = (diff != 0);
            e_total   += diff;
            e_bytes++;
            m_hist = nh;
            if (diff >= UNLOCK_BITS) begin
               m_bad++;
               if (m_bad == UNLOCK_BYTES) begin
                  e_locked = 0; e_lock_loss = 1; m_fill = 0; m_good = 0; m_bad = 0;
               end
            end else m_bad = 0;
         end
      end
      if (clr) begin
         e_total = 0;
         e_bytes = 0;
      end
   endtask

   function automatic longint sat(input longint v, input longint lim);
      return (v > lim) ? lim : v;
   endfunction

   // Per-cycle comparison of both instances against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("locked32",    bus32.locked,    e_locked);
         check("err_byte32",  bus32.err_byte,  e_err_byte);
         check("err_bits32",  bus32.err_bits,  e_err_bits);
         check("err_count32", bus32.err_count, sat(e_total, 64'hFFFF_FFFF));
         check("lock_loss32", bus32.lock_loss, e_lock_loss);
         check("locked4",     bus4.locked,     e_locked);
         check("err_bits4",   bus4.err_bits,   e_err_bits);
         check("err_count4",  bus4.err_count,  sat(e_total, 15));
         check("lock_loss4",  bus4.lock_loss,  e_lock_loss);
`ifdef PRBS_CHK_BYTECNT_EN
         check("byte_count32", bus32.byte_count, sat(e_bytes, 64'hFFFF_FFFF));
`endif
      end
   end

   task automatic drive(input logic [7:0] d, input bit v, input bit clr);
      @(negedge clk);
      data_in    = d;
      data_valid = v;
      clear      = clr;
      model_step(d, v, clr);
   endtask

   task automatic send(input logic [7:0] mask, input bit clr);
      drive(gen_next() ^ mask, 1'b1, clr);
   endtask

   task automatic idle(input int n, input bit clr);
      for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0, clr);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] two_bit_mask();
      int a, b;
      a = $urandom_range(0, 7);
      b = (a + $urandom_range(1, 7)) % 8;
      return 8'((1 << a) | (1 << b));
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_locked"},   bus32.locked,    0);
      check({tag, "_err_byte"}, bus32.err_byte,  0);
      check({tag, "_err_bits"}, bus32.err_bits,  0);
      check({tag, "_err_cnt"},  bus32.err_count, 0);
      check({tag, "_lockloss"}, bus32.lock_loss, 0);
      check({tag, "_err_cnt4"}, bus4.err_count,  0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      data_valid = 1'b0;
      clear      = 1'b0;
      model_reset();
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] b0, b1;
      rst_n = 1'b0; data_in = '0; data_valid = 1'b0; clear = 1'b0;
      model_reset();
      for (int i = 0; i < 15; i++) g_hist[i] = 1;
      chk_en = 1;
      repeat (2) @(negedge clk);
      check_all_zero("por");
      rst_n = 1'b1;

      // Clean stream from seed 7FFF; pin the first two generator bytes by hand.
      b0 = gen_next();
      b1 = gen_next();
      check("gen_byte0", b0, 8'h00);
      check("gen_byte1", b1, 8'h02);
      drive(b0, 1'b1, 1'b0);
      drive(b1, 1'b1, 1'b0);
      for (int i = 3; i <= 6; i++) begin
         send(8'h00, 1'b0);
         settle();
         check($sformatf("lock_at_byte%0d", i), bus32.locked, (i == 6) ? 1 : 0);
      end
      for (int i = 0; i < 1000; i++) send(8'h00, 1'b0);
      settle();
      check("clean_err_count", bus32.err_count, 0);

      // Single flipped bit while locked.
      send(8'h08, 1'b0);
      settle();
      check("flip_err_bits", bus32.err_bits, 1);
      check("flip_err_byte", bus32.err_byte, 1);
      check("flip_err_count", bus32.err_count, 1);
      send(8'h00, 1'b0);
      settle();
      check("flip_next_bits", bus32.err_bits, 0);
      check("flip_still_locked", bus32.locked, 1);

      // Four bad bytes drop lock; six clean bytes relock.
      for (int i = 0; i < 4; i++) send(two_bit_mask(), 1'b0);
      settle();
      check("unlock_loss", bus32.lock_loss, 1);
      check("unlock_locked", bus32.locked, 0);
      check("unlock_err_count", bus32.err_count, 9);
      for (int i = 0; i < 6; i++) send(8'h00, 1'b0);
      settle();
      check("relock", bus32.locked, 1);

      // Three bad then one good keeps lock.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) send(two_bit_mask(), 1'b0);
         send(8'h00, 1'b0);
      end
      settle();
      check("bad3_keeps_lock", bus32.locked, 1);

      // Saturation of the narrow counter, then clear colliding with an error byte.
      idle(1, 1'b1);
      for (int i = 0; i < 20; i++) send(8'(1 << $urandom_range(0, 7)), 1'b0);
      settle();
      check("sat_err_count4", bus4.err_count, 4'hF);
      check("sat_err_count32", bus32.err_count, 20);
      send(8'h40, 1'b1);
      settle();
      check("clr_err_count32", bus32.err_count, 0);
      check("clr_err_count4", bus4.err_count, 0);
      check("clr_err_bits", bus32.err_bits, 1);

      // All-zero input never locks.
      do_reset();
      for (int i = 0; i < 50; i++) drive(8'h00, 1'b1, 1'b0);
      settle();
      check("zero_no_lock", bus32.locked, 0);

      // 1-of-3 valid duty on a clean stream, with a reset pulse mid-stream.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 1; i <= 6; i++) begin
            send(8'h00, 1'b0);
            settle();
            check($sformatf("gap_lock%0d_byte%0d", r, i), bus32.locked, (i == 6) ? 1 : 0);
            idle(2, 1'b0);
         end
         for (int i = 0; i < 10; i++) begin
            send(8'h00, 1'b0);
            idle(2, 1'b0);
         end
         if (r == 0) do_reset();
      end

      // Mixed random traffic: gaps, error bursts, occasional clears.
      for (int i = 0; i < 3000; i++) begin
         int p;
         logic [7:0] m;
         bit c;
         p = $urandom_range(0, 99);
         c = ($urandom_range(0, 59) == 0);
         m = (p < 6) ? 8'($urandom) : (p < 12) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         if ($urandom_range(0, 2) == 0) idle(1, c);
         else send(m, c);
      end
      settle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
